// File: rtl/load_store_unit.sv
// Load/store unit: aligns and issues one data-memory access per request,
// extracts and extends load results, and flags misalignment or timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [3:0]  mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        timeout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        bad_req;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] lane;
  logic [31:0] ext;

  assign busy = (state != IDLE);

  always_comb begin
    bad_req = 1'b0;
    if (is_load) begin
      case (funct3[1:0])
        2'b00:   bad_req = 1'b0;
        2'b01:   bad_req = addr[0];
        default: bad_req = |addr[1:0];
      endcase
    end else begin
      case (mem_write)
        4'b0001: bad_req = 1'b0;
        4'b0011: bad_req = addr[0];
        4'b1111: bad_req = |addr[1:0];
        default: bad_req = 1'b1;
      endcase
    end
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = 32'h0;
    if (!is_load) begin
      be_next = 4'(mem_write << addr[1:0]);
      case (mem_write)
        4'b0001: wdata_next = {4{store_data[7:0]}};
        4'b0011: wdata_next = {2{store_data[15:0]}};
        default: wdata_next = store_data;
      endcase
    end
  end

  // Shift the addressed lane down to bit 0 before extending.
  always_comb begin
    lane = dmem_rdata >> {off_q, 3'b000};
    ext  = dmem_rdata;
    case (f3_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext = {24'h0, lane[7:0]};
      3'b101:  ext = {16'h0, lane[15:0]};
      default: ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'h0;
      ld_q       <= 1'b0;
      f3_q       <= 3'b0;
      off_q      <= 2'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      load_data  <= 32'h0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_req) begin
              state      <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state      <= ACCESS;
              cnt        <= 8'h0;
              dmem_req   <= 1'b1;
              dmem_we    <= !is_load;
              dmem_be    <= be_next;
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_wdata <= wdata_next;
              ld_q       <= is_load;
              f3_q       <= funct3;
              off_q      <= addr[1:0];
            end
          end
        end
        ACCESS: begin
          // Ack takes priority over an expiring timeout.
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            done     <= 1'b1;
            if (ld_q) load_data <= ext;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == TO_LAST) begin
              state    <= DONE;
              dmem_req <= 1'b0;
              done     <= 1'b1;
              timeout  <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with TIMEOUT_CYCLES=4.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [3:0]  mem_write = 4'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        timeout;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
    .funct3(funct3), .mem_write(mem_write), .addr(addr),
    .store_data(store_data), .busy(busy), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .done(done), .load_data(load_data),
    .misaligned(misaligned), .timeout(timeout)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        il;
    logic [2:0]  f3;
    logic [3:0]  mw;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          dly;
    int          lat;
    int          nreq;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ld;
    logic        mis;
    logic        to;
  } vec_t;

  vec_t v[16];

  task automatic run(input vec_t t, output int lat, output int nreq,
                     output logic [3:0] be, output logic we,
                     output logic [31:0] wa, output logic [31:0] wd,
                     output logic [31:0] ld, output logic mis,
                     output logic to, output int bad);
    lat = -1; nreq = 0; be = 4'h0; we = 1'b0; wa = 32'h0; wd = 32'h0;
    ld = 32'h0; mis = 1'b0; to = 1'b0; bad = 0;
    @(negedge clk);
    start = 1'b1; is_load = t.il; funct3 = t.f3; mem_write = t.mw;
    addr = t.a; store_data = t.sd;
    @(negedge clk);
    start = 1'b0; addr = 32'hFFFF_FFFF; store_data = 32'h5A5A_5A5A;
    mem_write = 4'b0110; funct3 = 3'b011; is_load = ~t.il;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      dmem_ack = 1'b0;
      if (dmem_req) begin
        if (nreq == 0) begin
          be = dmem_be; we = dmem_we; wa = dmem_addr; wd = dmem_wdata;
        end else if ({dmem_be, dmem_we, dmem_addr, dmem_wdata} !==
                     {be, we, wa, wd}) begin
          bad++;
        end
        nreq++;
        dmem_rdata = t.rd;
        if (t.dly >= 0 && nreq - 1 == t.dly) dmem_ack = 1'b1;
      end
      if ((misaligned || timeout) && !done) bad++;
      if (misaligned && timeout) bad++;
      if (done) begin
        lat = cyc; ld = load_data; mis = misaligned; to = timeout;
        break;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    @(negedge clk);
    if (done || busy || dmem_req) bad++;
  endtask

  initial begin
    int lat, nreq, bad;
    logic [3:0] be;
    logic we, mis, to;
    logic [31:0] wa, wd, ld;
    int reqs, dones;

    //      il f3     mw       addr          sd            rdata        dly lat nreq be      we wa            wd            ld            mis to
    v[0]  = '{0, 3'b000, 4'b0001, 32'h0000_1003, 32'h0000_00AB, 32'hFFFF_FFFF, 0, 2, 1, 4'b1000, 1, 32'h0000_1000, 32'hABAB_ABAB, 32'h0000_0000, 0, 0};
    v[1]  = '{1, 3'b000, 4'b0000, 32'h0000_2002, 32'h0,         32'h0080_FF00, 3, 5, 4, 4'b1111, 0, 32'h0000_2000, 32'h0,         32'hFFFF_FF80, 0, 0};
    v[2]  = '{1, 3'b100, 4'b0000, 32'h0000_2002, 32'h0,         32'h0080_FF00, 0, 2, 1, 4'b1111, 0, 32'h0000_2000, 32'h0,         32'h0000_0080, 0, 0};
    v[3]  = '{1, 3'b001, 4'b0000, 32'h0000_2001, 32'h0,         32'h1111_1111, 0, 1, 0, 4'b0000, 0, 32'h0,         32'h0,         32'h0000_0080, 1, 0};
    v[4]  = '{0, 3'b000, 4'b1111, 32'h0000_2002, 32'h1234_5678, 32'h1111_1111, 0, 1, 0, 4'b0000, 0, 32'h0,         32'h0,         32'h0000_0080, 1, 0};
    v[5]  = '{1, 3'b010, 4'b0000, 32'h0000_3000, 32'h0,         32'h2222_2222, -1, 5, 4, 4'b1111, 0, 32'h0000_3000, 32'h0,        32'h0000_0080, 0, 1};
    v[6]  = '{1, 3'b001, 4'b0000, 32'h0000_2002, 32'h0,         32'h8001_1234, 1, 3, 2, 4'b1111, 0, 32'h0000_2000, 32'h0,         32'hFFFF_8001, 0, 0};
    v[7]  = '{1, 3'b101, 4'b0000, 32'h0000_2000, 32'h0,         32'h8001_F234, 0, 2, 1, 4'b1111, 0, 32'h0000_2000, 32'h0,         32'h0000_F234, 0, 0};
    v[8]  = '{1, 3'b010, 4'b0000, 32'h0000_4004, 32'h0,         32'hDEAD_BEEF, 0, 2, 1, 4'b1111, 0, 32'h0000_4004, 32'h0,         32'hDEAD_BEEF, 0, 0};
    v[9]  = '{1, 3'b111, 4'b0000, 32'h0000_4008, 32'h0,         32'h1234_5678, 2, 4, 3, 4'b1111, 0, 32'h0000_4008, 32'h0,         32'h1234_5678, 0, 0};
    v[10] = '{0, 3'b000, 4'b0011, 32'h0000_5002, 32'hFFFF_BEEF, 32'h9999_9999, 0, 2, 1, 4'b1100, 1, 32'h0000_5000, 32'hBEEF_BEEF, 32'h1234_5678, 0, 0};
    v[11] = '{0, 3'b000, 4'b1111, 32'h0000_6004, 32'h0123_4567, 32'h9999_9999, 1, 3, 2, 4'b1111, 1, 32'h0000_6004, 32'h0123_4567, 32'h1234_5678, 0, 0};
    v[12] = '{0, 3'b000, 4'b0111, 32'h0000_7000, 32'h0123_4567, 32'h9999_9999, 0, 1, 0, 4'b0000, 0, 32'h0,         32'h0,         32'h1234_5678, 1, 0};
    v[13] = '{1, 3'b000, 4'b0000, 32'h0000_2001, 32'h0,         32'h0000_7F00, 0, 2, 1, 4'b1111, 0, 32'h0000_2000, 32'h0,         32'h0000_007F, 0, 0};
    v[14] = '{1, 3'b100, 4'b0000, 32'h0000_2003, 32'h0,         32'hA500_0000, 0, 2, 1, 4'b1111, 0, 32'h0000_2000, 32'h0,         32'h0000_00A5, 0, 0};
    v[15] = '{1, 3'b001, 4'b0000, 32'h0000_2003, 32'h0,         32'h3333_3333, 0, 1, 0, 4'b0000, 0, 32'h0,         32'h0,         32'h0000_00A5, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst req", 32'(dmem_req), 32'h0);
    chk("rst we", 32'(dmem_we), 32'h0);
    chk("rst be", 32'(dmem_be), 32'h0);
    chk("rst addr", dmem_addr, 32'h0);
    chk("rst wdata", dmem_wdata, 32'h0);
    chk("rst ld", load_data, 32'h0);
    chk("rst flags", 32'({done, misaligned, timeout}), 32'h0);
    rst_n = 1'b1;

    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("idle ack busy", 32'(busy), 32'h0);
    chk("idle ack done", 32'(done), 32'h0);

    for (int i = 0; i < 16; i++) begin
      run(v[i], lat, nreq, be, we, wa, wd, ld, mis, to, bad);
      chk($sformatf("v%0d lat", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d nreq", i), 32'(nreq), 32'(v[i].nreq));
      chk($sformatf("v%0d ld", i), ld, v[i].ld);
      chk($sformatf("v%0d mis", i), 32'(mis), 32'(v[i].mis));
      chk($sformatf("v%0d to", i), 32'(to), 32'(v[i].to));
      chk($sformatf("v%0d proto", i), 32'(bad), 32'h0);
      if (nreq > 0) begin
        chk($sformatf("v%0d be", i), 32'(be), 32'(v[i].be));
        chk($sformatf("v%0d we", i), 32'(we), 32'(v[i].we));
        chk($sformatf("v%0d waddr", i), wa, v[i].wa);
        if (!v[i].il) chk($sformatf("v%0d wdata", i), wd, v[i].wd);
      end
    end

    // start held high across ACCESS and DONE
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; funct3 = 3'b010;
    addr = 32'h0000_0100; dmem_rdata = 32'h0000_0011;
    reqs = 0;
    @(negedge clk);
    chk("hold req c1", 32'(dmem_req), 32'h1);
    reqs += int'(dmem_req);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("hold done c2", 32'(done), 32'h1);
    reqs += int'(dmem_req);
    @(negedge clk);
    chk("hold busy c3", 32'(busy), 32'h0);
    reqs += int'(dmem_req);
    chk("hold reqs", 32'(reqs), 32'h1);
    @(negedge clk);
    chk("hold req c4", 32'(dmem_req), 32'h1);
    start = 1'b0; dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("hold done c5", 32'(done), 32'h1);
    chk("hold ld", load_data, 32'h0000_0011);
    @(negedge clk);

    // reset in the second ACCESS cycle, then a late ack
    start = 1'b1; is_load = 1'b0; mem_write = 4'b1111;
    addr = 32'h0000_8000; store_data = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    chk("rst2 req c1", 32'(dmem_req), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; dmem_ack = 1'b1;
    chk("rst2 busy", 32'(busy), 32'h0);
    chk("rst2 req", 32'(dmem_req), 32'h0);
    chk("rst2 we be", 32'({dmem_we, dmem_be}), 32'h0);
    chk("rst2 addr", dmem_addr, 32'h0);
    chk("rst2 wdata", dmem_wdata, 32'h0);
    chk("rst2 ld", load_data, 32'h0);
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      dones += int'(done || busy || dmem_req);
    end
    chk("rst2 no done", 32'(dones), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
